// File: rtl/sf_camera_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : sf_camera_frame_packer
// Description : Samples a parallel camera bus in the pixel clock domain and
//               packs PIX_WIDTH-bit pixels into WORD_WIDTH-bit words. The
//               words are written to the write side of an external ping-pong
//               FIFO, one line per buffer. Frames are tracked with vsync.
//               Supports line-limited, single-shot and continuous capture
//               and reports dropped pixels through a sticky overflow flag.
// Ports       : i_pix_clk / rst       - clock, synchronous active-high reset
//               i_enable, i_single_shot, i_lines_per_frame, i_clear_status
//                                     - capture control
//               o_busy, o_captured, o_overflow, o_line_count, o_frame_count
//                                     - capture status
//               i_vsync, i_hsync, i_pix_data
//                                     - camera pins
//               i_wfifo_ready, o_wfifo_activate, i_wfifo_size,
//               o_wfifo_strobe, o_wfifo_data
//                                     - ppfifo write side
// Revision    : 1.0 - initial release
// ============================================================================
module sf_camera_frame_packer #(
    parameter int   PIX_WIDTH       = 8,
    parameter int   WORD_WIDTH      = 32,
    parameter int   FIFO_SIZE_WIDTH = 24,
    parameter int   LINE_CNT_WIDTH  = 16,
    parameter logic VSYNC_ACTIVE    = 1'b1,
    parameter logic HSYNC_ACTIVE    = 1'b1
) (
    input  logic                       i_pix_clk,
    input  logic                       rst,
    input  logic                       i_enable,
    input  logic                       i_single_shot,
    input  logic [LINE_CNT_WIDTH-1:0]  i_lines_per_frame,
    input  logic                       i_clear_status,
    output logic                       o_busy,
    output logic                       o_captured,
    output logic                       o_overflow,
    output logic [LINE_CNT_WIDTH-1:0]  o_line_count,
    output logic [15:0]                o_frame_count,
    input  logic                       i_vsync,
    input  logic                       i_hsync,
    input  logic [PIX_WIDTH-1:0]       i_pix_data,
    input  logic [1:0]                 i_wfifo_ready,
    output logic [1:0]                 o_wfifo_activate,
    input  logic [FIFO_SIZE_WIDTH-1:0] i_wfifo_size,
    output logic                       o_wfifo_strobe,
    output logic [WORD_WIDTH-1:0]      o_wfifo_data
);

    localparam int                 c_PPW       = WORD_WIDTH / PIX_WIDTH;
    localparam int                 c_SLOT_W    = (c_PPW > 1) ? $clog2(c_PPW) : 1;
    localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(c_PPW - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_ACTIVE     = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_FRAME_DONE = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic                        r_vs_q;
    logic                        r_hs_q;
    logic                        r_need_low;
    logic                        r_rel_pend;
    logic                        r_overflow;
    logic [1:0]                  r_activate;
    logic                        r_strobe;
    logic [WORD_WIDTH-1:0]       r_wdata;
    logic [WORD_WIDTH-1:0]       r_acc;
    logic [c_SLOT_W-1:0]         r_slot;
    logic [FIFO_SIZE_WIDTH-1:0]  r_word_cnt;
    logic [LINE_CNT_WIDTH-1:0]   r_line_count;
    logic [15:0]                 r_frame_count;

    logic                        w_vs_act;
    logic                        w_vs_rise;
    logic                        w_vs_fall;
    logic                        w_hs_act;
    logic                        w_hs_fall;
    logic                        w_held;
    logic                        w_full;
    logic                        w_limit_hit;
    logic                        w_pix_req;
    logic                        w_drop;
    logic                        w_accept;
    logic                        w_eol;
    logic                        w_partial;
    logic                        w_pack_flush;
    logic                        w_release;
    logic                        w_acquire;
    logic                        w_lost;
    logic [WORD_WIDTH-1:0]       w_acc_next;

    // Sync edge detection compares the raw pin against its registered copy.
    assign w_vs_act  = (i_vsync == VSYNC_ACTIVE);
    assign w_hs_act  = (i_hsync == HSYNC_ACTIVE);
    assign w_vs_rise = w_vs_act && (r_vs_q != VSYNC_ACTIVE);
    assign w_vs_fall = !w_vs_act && (r_vs_q == VSYNC_ACTIVE);
    assign w_hs_fall = !w_hs_act && (r_hs_q == HSYNC_ACTIVE);

    assign w_held      = |r_activate;
    assign w_full      = (r_word_cnt == i_wfifo_size);
    assign w_limit_hit = (i_lines_per_frame != '0) && (r_line_count == i_lines_per_frame);
    assign w_partial   = (r_slot != '0);

    assign w_pix_req = (r_state == ST_ACTIVE) && w_hs_act;
    assign w_drop    = w_pix_req && (!w_held || w_full);
    assign w_accept  = w_pix_req && !w_drop;
    assign w_eol     = (r_state == ST_ACTIVE) && w_hs_fall;

    // A pending partial word is pushed out at end of line or on frame flush.
    assign w_pack_flush = (w_eol || (r_state == ST_FLUSH)) && w_partial;

    // Release after a padded partial word (one cycle later so strobe and
    // activate do not move together), when the buffer fills, or at end of
    // line / flush when whole words were written. Empty buffers are kept.
    assign w_release = w_held && !w_pack_flush &&
                       (r_rel_pend ||
                        ((r_word_cnt != '0) &&
                         (w_full || ((w_eol || (r_state == ST_FLUSH)) && !w_partial))));

    assign w_acquire = !w_held && (i_wfifo_ready != 2'b00) &&
                       ((r_state == ST_WAIT_FRAME) || (r_state == ST_ACTIVE));

    // A partial word left over after its buffer was lost is discarded.
    assign w_lost = w_drop || (w_pack_flush && !w_held);

    assign w_acc_next = r_acc | (WORD_WIDTH'(i_pix_data) << (32'(r_slot) * PIX_WIDTH));

    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && !r_need_low) begin
                    w_state_next = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_vs_rise) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Disabling waits for the line in progress to finish.
                if (w_vs_fall || w_limit_hit || (!i_enable && !w_hs_act)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!w_partial && !r_rel_pend && !(w_held && (r_word_cnt != '0))) begin
                    w_state_next = ST_FRAME_DONE;
                end
            end
            ST_FRAME_DONE: begin
                w_state_next = (i_single_shot || !i_enable) ? ST_IDLE : ST_WAIT_FRAME;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            r_vs_q        <= 1'b0;
            r_hs_q        <= 1'b0;
            r_need_low    <= 1'b0;
            r_rel_pend    <= 1'b0;
            r_overflow    <= 1'b0;
            r_activate    <= 2'b00;
            r_strobe      <= 1'b0;
            r_wdata       <= '0;
            r_acc         <= '0;
            r_slot        <= '0;
            r_word_cnt    <= '0;
            r_line_count  <= '0;
            r_frame_count <= '0;
        end else begin
            r_vs_q   <= i_vsync;
            r_hs_q   <= i_hsync;
            r_strobe <= 1'b0;

            if (i_clear_status) begin
                r_overflow <= 1'b0;
            end else if (w_lost) begin
                r_overflow <= 1'b1;
            end

            // Single-shot re-arm requires i_enable to be seen low first.
            if (!i_enable) begin
                r_need_low <= 1'b0;
            end else if ((r_state == ST_FRAME_DONE) && i_single_shot) begin
                r_need_low <= 1'b1;
            end

            if ((r_state == ST_WAIT_FRAME) && w_vs_rise) begin
                r_line_count <= '0;
            end else if (w_eol) begin
                r_line_count <= r_line_count + LINE_CNT_WIDTH'(1);
            end

            if (r_state == ST_FRAME_DONE) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (w_acquire) begin
                r_activate <= i_wfifo_ready[0] ? 2'b01 : 2'b10;
            end

            if (w_pack_flush) begin
                r_acc  <= '0;
                r_slot <= '0;
                if (w_held) begin
                    r_strobe   <= 1'b1;
                    r_wdata    <= r_acc;
                    r_word_cnt <= r_word_cnt + FIFO_SIZE_WIDTH'(1);
                    r_rel_pend <= 1'b1;
                end
            end else if (w_accept) begin
                if (r_slot == c_LAST_SLOT) begin
                    r_strobe   <= 1'b1;
                    r_wdata    <= w_acc_next;
                    r_word_cnt <= r_word_cnt + FIFO_SIZE_WIDTH'(1);
                    r_acc      <= '0;
                    r_slot     <= '0;
                end else begin
                    r_acc  <= w_acc_next;
                    r_slot <= r_slot + c_SLOT_W'(1);
                end
            end else if (w_eol) begin
                r_slot <= '0;
            end

            // Placed last: releasing a buffer always restarts its word count.
            if (w_release) begin
                r_activate <= 2'b00;
                r_word_cnt <= '0;
                r_rel_pend <= 1'b0;
            end
        end
    end

    assign o_busy           = (r_state != ST_IDLE);
    assign o_captured       = (r_state == ST_FRAME_DONE);
    assign o_overflow       = r_overflow;
    assign o_line_count     = r_line_count;
    assign o_frame_count    = r_frame_count;
    assign o_wfifo_activate = r_activate;
    assign o_wfifo_strobe   = r_strobe;
    assign o_wfifo_data     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sf_camera_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sf_camera_frame_packer
// Description : Self-checking bench for sf_camera_frame_packer with a small
//               ping-pong FIFO ready model and a write-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sf_camera_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic [15:0] lines_per_frame = 16'd0;
    logic        clear_status = 1'b0;
    logic        busy;
    logic        captured;
    logic        overflow;
    logic [15:0] line_count;
    logic [15:0] frame_count;
    logic        vsync = 1'b0;
    logic        hsync = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic [1:0]  rdy;
    logic [1:0]  act;
    logic [23:0] fifo_size = 24'd256;
    logic        strobe;
    logic [31:0] wdata;

    logic [1:0]  r_rdy = 2'b11;
    logic [1:0]  r_act_q = 2'b00;
    logic [1:0]  rdy_mask = 2'b11;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  act;   // 00 = any held buffer
    } exp_t;

    typedef struct {
        int              npix;
        logic [7:0]      base;
        int              nwords;
        logic [2:0][31:0] w;
        logic            partial;
    } row_t;

    exp_t exp_q[$];
    row_t rows[5];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cap_cnt = 0;

    always #5 clk = ~clk;

    sf_camera_frame_packer dut (
        .i_pix_clk         (clk),
        .rst               (rst),
        .i_enable          (enable),
        .i_single_shot     (single_shot),
        .i_lines_per_frame (lines_per_frame),
        .i_clear_status    (clear_status),
        .o_busy            (busy),
        .o_captured        (captured),
        .o_overflow        (overflow),
        .o_line_count      (line_count),
        .o_frame_count     (frame_count),
        .i_vsync           (vsync),
        .i_hsync           (hsync),
        .i_pix_data        (pix),
        .i_wfifo_ready     (rdy),
        .o_wfifo_activate  (act),
        .i_wfifo_size      (fifo_size),
        .o_wfifo_strobe    (strobe),
        .o_wfifo_data      (wdata)
    );

    // Ping-pong FIFO write side: a buffer stops being ready once activated
    // and is drained immediately after it is released.
    always @(posedge clk) begin
        r_act_q <= act;
        for (int i = 0; i < 2; i++) begin
            if (act[i]) begin
                r_rdy[i] <= 1'b0;
            end else if (r_act_q[i]) begin
                r_rdy[i] <= 1'b1;
            end
        end
    end
    assign rdy = r_rdy & rdy_mask;

    always @(negedge clk) begin : mon
        exp_t e;
        if (captured) cap_cnt++;
        if (strobe) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got data %h act %b, required no strobe", wdata, act);
            end else begin
                e = exp_q.pop_front();
                if ((wdata !== e.data) ||
                    ((e.act != 2'b00) ? (act !== e.act) : (act == 2'b00))) begin
                    n_fail++;
                    $display("FAIL strobe_word: got data %h act %b, required data %h act %b",
                             wdata, act, e.data, e.act);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] a);
        exp_t e;
        e.data = d;
        e.act  = a;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        idle(3);
    endtask

    task automatic end_frame();
        vsync = 1'b0;
        idle(6);
    endtask

    task automatic drive_pixels(input int n, input logic [7:0] base);
        hsync = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix = base + 8'(i);
            tick();
        end
    endtask

    task automatic end_line();
        hsync = 1'b0;
        pix   = 8'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1);
    end

    initial begin
        rows[0] = '{npix: 8,  base: 8'h01, nwords: 2, w: {32'h0, 32'h08070605, 32'h04030201}, partial: 1'b0};
        rows[1] = '{npix: 6,  base: 8'h11, nwords: 2, w: {32'h0, 32'h00001615, 32'h14131211}, partial: 1'b1};
        rows[2] = '{npix: 1,  base: 8'hA0, nwords: 1, w: {32'h0, 32'h0, 32'h000000A0},        partial: 1'b1};
        rows[3] = '{npix: 12, base: 8'h21, nwords: 3, w: {32'h2C2B2A29, 32'h28272625, 32'h24232221}, partial: 1'b0};
        rows[4] = '{npix: 4,  base: 8'h31, nwords: 1, w: {32'h0, 32'h0, 32'h34333231},        partial: 1'b0};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_activate", 32'(act), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_line_count", 32'(line_count), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_captured", 32'(captured), 32'd0);

        // Table of lines in one continuous frame, with end-of-line timing
        tick();
        enable = 1'b1;
        cap_cnt = 0;
        idle(3);
        start_frame();
        @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        tick();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < rows[r].nwords; k++) push(rows[r].w[k], 2'b00);
            drive_pixels(rows[r].npix, rows[r].base);
            end_line();
            @(negedge clk);
            check("lc_at_N", 32'(line_count), 32'(r));
            tick();
            @(negedge clk);
            check("lc_at_N1", 32'(line_count), 32'(r + 1));
            if (rows[r].partial) begin
                check("pad_strobe_N1", 32'(strobe), 32'd1);
                check("act_held_N1", 32'(act != 2'b00), 32'd1);
                tick();
                @(negedge clk);
                check("act_rel_N2", 32'(act), 32'd0);
            end else begin
                check("act_rel_N1", 32'(act), 32'd0);
            end
            idle(4);
        end
        end_frame();
        check("tbl_line_count", 32'(line_count), 32'd5);
        check("tbl_frame_count", 32'(frame_count), 32'd1);
        check("tbl_captured", 32'(cap_cnt), 32'd1);
        check("tbl_overflow", 32'(overflow), 32'd0);
        check("tbl_queue_empty", 32'(exp_q.size()), 32'd0);

        // Line limit of 2 in a 3-line frame
        do_reset();
        lines_per_frame = 16'd2;
        cap_cnt = 0;
        idle(3);
        start_frame();
        push(32'h44434241, 2'b00);
        drive_pixels(4, 8'h41); end_line(); idle(5);
        push(32'h54535251, 2'b00);
        drive_pixels(4, 8'h51); end_line(); idle(5);
        drive_pixels(4, 8'h61); end_line(); idle(5);
        end_frame();
        check("lim_line_count", 32'(line_count), 32'd2);
        check("lim_frame_count", 32'(frame_count), 32'd1);
        check("lim_captured", 32'(cap_cnt), 32'd1);
        check("lim_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-line discards the partial word
        lines_per_frame = 16'd0;
        idle(2);
        start_frame();
        push(32'h94939291, 2'b00);
        drive_pixels(4, 8'h91); end_line(); idle(5);
        push(32'hA4A3A2A1, 2'b00);
        drive_pixels(5, 8'hA1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_activate", 32'(act), 32'd0);
        check("midrst_strobe", 32'(strobe), 32'd0);
        check("midrst_line_count", 32'(line_count), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        end_line();
        vsync = 1'b0;
        idle(8);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        // No buffer ready: pixels dropped, sticky overflow, clear pulse
        rdy_mask = 2'b00;
        do_reset();
        idle(3);
        start_frame();
        drive_pixels(4, 8'hC1); end_line(); idle(3);
        check("nordy_overflow", 32'(overflow), 32'd1);
        idle(3);
        check("nordy_sticky", 32'(overflow), 32'd1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        @(negedge clk);
        check("nordy_cleared", 32'(overflow), 32'd0);
        end_frame();
        check("nordy_queue_empty", 32'(exp_q.size()), 32'd0);
        rdy_mask = 2'b11;

        // Buffer full mid-line: switch to the other buffer, gap dropped
        fifo_size = 24'd2;
        do_reset();
        idle(3);
        start_frame();
        push(32'h04030201, 2'b01);
        push(32'h08070605, 2'b01);
        push(32'h0E0D0C0B, 2'b10);
        push(32'h0000100F, 2'b10);
        drive_pixels(16, 8'h01); end_line(); idle(5);
        check("full_overflow", 32'(overflow), 32'd1);
        end_frame();
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        fifo_size = 24'd256;

        // Single shot over two frames
        do_reset();
        single_shot = 1'b1;
        cap_cnt = 0;
        idle(3);
        start_frame();
        push(32'h74737271, 2'b00);
        drive_pixels(4, 8'h71); end_line(); idle(5);
        end_frame();
        check("ss_busy_after1", 32'(busy), 32'd0);
        start_frame();
        drive_pixels(4, 8'h81); end_line(); idle(5);
        end_frame();
        check("ss_captured", 32'(cap_cnt), 32'd1);
        check("ss_busy_after2", 32'(busy), 32'd0);
        check("ss_frame_count", 32'(frame_count), 32'd1);
        check("ss_queue_empty", 32'(exp_q.size()), 32'd0);
        enable = 1'b0;
        single_shot = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sf_camera_frame_packer.md
Name: sf_camera_frame_packer

Overview:
Parametrised successor to the single-line camera capture path. It samples a parallel camera bus in the i_pix_clk domain and packs PIX_WIDTH pixels into WORD_WIDTH words. It drives the write side of an external ping-pong FIFO (ppfifo) with one line per buffer, tracks frames using vsync, and supports line-limited, single-shot and continuous capture with overflow reporting. It sits between the camera pins and the ppfifo whose read side is in the bus clock domain.

Parameters:
PIX_WIDTH, 8, bits per pixel sample.
WORD_WIDTH, 32, FIFO word width; must be an integer multiple of PIX_WIDTH; PPW = WORD_WIDTH/PIX_WIDTH.
FIFO_SIZE_WIDTH, 24, width of the ppfifo size bus.
LINE_CNT_WIDTH, 16, width of the line counter and the line limit.
VSYNC_ACTIVE, 1, level of i_vsync that marks an active frame.
HSYNC_ACTIVE, 1, level of i_hsync that marks valid pixels.

Ports:
i_pix_clk  in  1  pixel clock; all logic runs in this domain
rst  in  1  reset, synchronous, active-high
i_enable  in  1  capture enable
i_single_shot  in  1  1 = stop after one frame; 0 = continuous
i_lines_per_frame  in  LINE_CNT_WIDTH  frame line limit; 0 = bounded by vsync only
i_clear_status  in  1  pulse; clears o_overflow
o_busy  out  1  high in any state other than IDLE
o_captured  out  1  one-cycle pulse at frame end
o_overflow  out  1  sticky; a pixel was dropped
o_line_count  out  LINE_CNT_WIDTH  lines completed in the current frame
o_frame_count  out  16  frames completed; wraps
i_vsync, i_hsync  in  1 each  camera syncs
i_pix_data  in  PIX_WIDTH  pixel bus
i_wfifo_ready  in  2  ppfifo write_ready
o_wfifo_activate  out  2  ppfifo write_activate
i_wfifo_size  in  FIFO_SIZE_WIDTH  ppfifo write_fifo_size
o_wfifo_strobe  out  1  ppfifo write_strobe
o_wfifo_data  out  WORD_WIDTH  ppfifo write_data

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, any held buffer released (activate = 0). Reset asserted mid-line takes effect on the next edge; the partial word is discarded.
- Sync edges: vsync and hsync are registered once, and edges are detected against the registered copy. Pixels are sampled whenever the raw i_hsync is at its active level and a frame is active.
- States:
  - IDLE: go to WAIT_FRAME when i_enable=1. After a single-shot frame, stay in IDLE until i_enable has been seen low.
  - WAIT_FRAME: wait for the vsync inactive-to-active edge, so mid-frame starts are skipped. On the edge, clear o_line_count and go to ACTIVE.
  - ACTIVE: capture lines.
  - FLUSH: write the partial word, then release the buffer.
  - FRAME_DONE: one cycle; o_captured=1, o_frame_count+1. Then go to IDLE if i_single_shot=1 or i_enable=0, otherwise WAIT_FRAME.
- Buffer acquisition: when activate==0 and ready!=0, assert activate[0] if ready[0]=1, else activate[1]. Acquisition takes one cycle. A new buffer is never taken while one is held.
- Packing: the first pixel of a word goes in bits [PIX_WIDTH-1:0], the next in the next slot, and so on.
  - When slot PPW-1 is filled, o_wfifo_strobe=1 on the following cycle with the completed word, and the per-buffer word count +1.
- Dropped pixels: a pixel sampled while no buffer is held, or while the word count == i_wfifo_size, is dropped and sets o_overflow. It does not advance the slot index.
- Buffer full mid-line: on the cycle the count reaches i_wfifo_size, release the buffer. Acquisition may take the other buffer and the line continues there. Pixels in the gap are dropped and flagged.
- End of line (hsync active-to-inactive, detected at cycle N):
  - If a partial word is pending, strobe it at N+1 with unused slots zero, and clear activate at N+2.
  - Otherwise clear activate at N+1, provided the word count is > 0.
  - o_line_count increments at N+1.
  - The slot index resets to 0.
- Frame end: a vsync active-to-inactive edge, or o_line_count reaching a nonzero i_lines_per_frame. After a line limit is reached, further lines in the frame are ignored until vsync goes inactive.
- Simultaneous events: if the hsync end and the vsync end coincide, the line flush completes first, then FRAME_DONE.
- i_enable low mid-frame: the current line is finished normally, then FRAME_DONE is entered and the block goes to IDLE.
- Clearing vs setting overflow: i_clear_status has priority over a new overflow set in the same cycle.
- Counters wrap at full width. Strobe and activate never change in the same cycle for the same buffer.

Test Plan:
- PIX 8/WORD 32, both buffers ready, one 8-pixel line 0x01..0x08 -> strobes with 0x04030201 then 0x08070605; activate[0] drops 1 cycle after the hsync fall; o_line_count=1.
- 6-pixel line 0x11..0x16 -> words 0x14131211 and 0x00001615; padded strobe at N+1; activate cleared at N+2.
- i_lines_per_frame=2, vsync frame of 3 lines -> 2 lines written, third line produces no strobes, one o_captured pulse, o_frame_count=1.
- i_wfifo_ready=0, 4-pixel line -> no strobe; o_overflow=1 until an i_clear_status pulse, then 0.
- i_wfifo_size=2, 16-pixel line -> 2 words in buffer 0, activate[0] released, activate[1] asserted next cycle, o_overflow=1.
- i_single_shot=1 over 2 vsync frames -> exactly 1 o_captured and o_busy=0 afterwards. rst mid-line -> activate=0, strobe=0, counts=0 the next cycle.
